// File: rtl/act_bus_serializer_if.sv
// act_bus_serializer_if: wide activation beat in, OUT_LANES-wide chunk stream out
// Signals: in_fixed_data/in_fixed_data_vld/in_ready (wide side), out_data/out_lane_mask/out_chunk_idx/out_vld/out_ready/out_last (chunk side), err_drop (sticky drop flag)
interface act_bus_serializer_if #(
  parameter int BUS_NUM = 64,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int OUT_LANES = 4
);
  localparam int NUM_CHUNKS = BUS_NUM / OUT_LANES;
  localparam int CW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] in_fixed_data;
  logic [BUS_NUM-1:0] in_fixed_data_vld;
  logic in_ready;
  logic [OUT_LANES*FIXED_DATA_WIDTH-1:0] out_data;
  logic [OUT_LANES-1:0] out_lane_mask;
  logic [CW-1:0] out_chunk_idx;
  logic out_vld;
  logic out_ready;
  logic out_last;
  logic err_drop;
  modport slave (
    input in_fixed_data, in_fixed_data_vld, out_ready,
    output in_ready, out_data, out_lane_mask, out_chunk_idx, out_vld, out_last, err_drop
  );
  modport master (
    output in_fixed_data, in_fixed_data_vld, out_ready,
    input in_ready, out_data, out_lane_mask, out_chunk_idx, out_vld, out_last, err_drop
  );
endinterface

// File: rtl/act_bus_serializer.sv
// act_bus_serializer: captures one wide activation beat and emits its nonzero OUT_LANES chunks in ascending order
// Ports: clk, rst (async active-high), bus (slave modport of act_bus_serializer_if)
module act_bus_serializer #(
  parameter int BUS_NUM = 64,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int OUT_LANES = 4
) (
  input logic clk,
  input logic rst,
  act_bus_serializer_if.slave bus
);
  localparam int W = FIXED_DATA_WIDTH;
  localparam int NC = BUS_NUM / OUT_LANES;
  localparam int CW = NC > 1 ? $clog2(NC) : 1;
  localparam int CHW = OUT_LANES * W;
  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_next_state;
  logic [BUS_NUM*W-1:0] r_data, w_in_masked;
  logic [BUS_NUM-1:0] r_vld;
  logic [CW-1:0] r_ptr, w_first, w_next;
  logic [CHW-1:0] w_chunk;
  logic [OUT_LANES-1:0] w_mask;
  logic w_has_next, w_beat, w_send, w_xfer, r_err;
  assign w_beat = |bus.in_fixed_data_vld;
  assign w_send = r_state == SEND;
  assign w_xfer = w_send && bus.out_ready;
  // Invalid lanes are zeroed at capture so the buffer only ever holds presentable data
  always_comb begin
    w_in_masked = '0;
    for (int i = 0; i < BUS_NUM; i++)
      w_in_masked[i*W +: W] = bus.in_fixed_data_vld[i] ? bus.in_fixed_data[i*W +: W] : '0;
  end
  // Descending scans so the last hit is the lowest qualifying chunk
  always_comb begin
    w_first = '0;
    w_next = '0;
    w_has_next = 1'b0;
    w_chunk = '0;
    w_mask = '0;
    for (int c = NC - 1; c >= 0; c--) begin
      if (|bus.in_fixed_data_vld[c*OUT_LANES +: OUT_LANES]) w_first = CW'(c);
      if (CW'(c) > r_ptr && |r_vld[c*OUT_LANES +: OUT_LANES]) begin
        w_next = CW'(c);
        w_has_next = 1'b1;
      end
      if (CW'(c) == r_ptr) begin
        w_chunk = r_data[c*CHW +: CHW];
        w_mask = r_vld[c*OUT_LANES +: OUT_LANES];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next_state;
  end
  always_comb begin
    w_next_state = r_state == IDLE ? (w_beat ? SEND : IDLE) : (w_xfer && !w_has_next ? IDLE : SEND);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_vld <= '0;
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_beat) begin
        r_data <= w_in_masked;
        r_vld <= bus.in_fixed_data_vld;
        r_ptr <= w_first;
      end else if (w_xfer && w_has_next) begin
        r_ptr <= w_next;
      end
      if (w_send && w_beat) r_err <= 1'b1;
    end
  end
  assign bus.in_ready = r_state == IDLE && !rst;
  assign bus.out_vld = w_send;
  assign bus.out_data = w_send ? w_chunk : '0;
  assign bus.out_lane_mask = w_send ? w_mask : '0;
  assign bus.out_chunk_idx = r_ptr;
  assign bus.out_last = w_send && !w_has_next;
  assign bus.err_drop = r_err;
endmodule

// File: tb/tb_act_bus_serializer.sv
// tb_act_bus_serializer: scoreboard bench with directed and random beats for act_bus_serializer
module tb_act_bus_serializer;
  logic clk, rst;
  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;
  typedef struct {
    logic [15:0] data;
    logic [1:0] mask;
    logic [1:0] idx;
    logic last;
  } exp_t;
  exp_t sb[$];
  logic pv = 1'b0;
  logic [15:0] p_data;
  logic [1:0] p_mask, p_idx;
  logic p_last;
  act_bus_serializer_if #(.BUS_NUM(8), .FIXED_DATA_WIDTH(8), .OUT_LANES(2)) bus ();
  act_bus_serializer #(.BUS_NUM(8), .FIXED_DATA_WIDTH(8), .OUT_LANES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_beat(input logic [63:0] d, input logic [7:0] v);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      e.mask = v[2*c +: 2];
      if (e.mask != 2'b00) begin
        e.idx = 2'(c);
        e.last = (v >> (2*c + 2)) == 8'h00;
        for (int j = 0; j < 2; j++) e.data[8*j +: 8] = e.mask[j] ? d[8*(2*c+j) +: 8] : 8'h00;
        sb.push_back(e);
      end
    end
  endtask
  task automatic step(input logic [63:0] d, input logic [7:0] v, input logic r);
    bus.out_ready = r;
    bus.in_fixed_data = d;
    bus.in_fixed_data_vld = v;
    if (v != 8'h00) begin
      if (bus.in_ready) push_beat(d, v);
      else exp_err = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("err_drop", 32'(bus.err_drop), 32'(exp_err));
  endtask
  task automatic drain(output int n);
    n = 0;
    while (bus.out_vld && n < 100) begin
      step(64'h0, 8'h00, 1'b1);
      n++;
    end
  endtask
  always @(negedge clk) begin
    if (rst) pv = 1'b0;
    else begin
      chk("in_ready_vs_out_vld", 32'(bus.in_ready), 32'(!bus.out_vld));
      if (pv && bus.out_vld) begin
        chk("hold_data", 32'(bus.out_data), 32'(p_data));
        chk("hold_mask", 32'(bus.out_lane_mask), 32'(p_mask));
        chk("hold_idx", 32'(bus.out_chunk_idx), 32'(p_idx));
        chk("hold_last", 32'(bus.out_last), 32'(p_last));
      end
      if (bus.out_vld && bus.out_ready) begin
        if (sb.size() == 0) chk("unexpected_chunk", 32'(bus.out_chunk_idx), 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.data));
          chk("out_lane_mask", 32'(bus.out_lane_mask), 32'(e.mask));
          chk("out_chunk_idx", 32'(bus.out_chunk_idx), 32'(e.idx));
          chk("out_last", 32'(bus.out_last), 32'(e.last));
        end
      end
      pv = bus.out_vld && !bus.out_ready;
      p_data = bus.out_data;
      p_mask = bus.out_lane_mask;
      p_idx = bus.out_chunk_idx;
      p_last = bus.out_last;
    end
  end
  initial begin
    int n;
    rst = 1'b1;
    bus.in_fixed_data = '0;
    bus.in_fixed_data_vld = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_err_drop", 32'(bus.err_drop), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) step(64'(k + 5) * 64'h1111, 8'h00, 1'b1);
    chk("zero_vld_out_vld", 32'(bus.out_vld), 32'd0);
    chk("zero_vld_err", 32'(bus.err_drop), 32'd0);
    step(64'h0807060504030201, 8'hFF, 1'b1);
    drain(n);
    chk("full_beat_cycles", 32'(n), 32'd4);
    chk("full_beat_in_ready", 32'(bus.in_ready), 32'd1);
    step(64'hA1B2C3D4E5F60718, 8'h30, 1'b1);
    chk("sparse_idx", 32'(bus.out_chunk_idx), 32'd2);
    drain(n);
    chk("sparse_cycles", 32'(n), 32'd1);
    step(64'h8877665544332211, 8'h81, 1'b0);
    for (int k = 0; k < 3; k++) step(64'h0, 8'h00, 1'b0);
    chk("stall_idx", 32'(bus.out_chunk_idx), 32'd0);
    chk("stall_mask", 32'(bus.out_lane_mask), 32'd1);
    chk("stall_data", 32'(bus.out_data), 32'h0011);
    drain(n);
    chk("stall_cycles", 32'(n), 32'd2);
    step(64'h1122334455667788, 8'hFF, 1'b0);
    step(64'hDEADBEEFCAFEF00D, 8'h0F, 1'b0);
    chk("drop_err", 32'(bus.err_drop), 32'd1);
    chk("drop_idx_kept", 32'(bus.out_chunk_idx), 32'd0);
    drain(n);
    chk("drop_cycles", 32'(n), 32'd4);
    step(64'h00000000000000AB, 8'h01, 1'b1);
    drain(n);
    chk("err_sticky", 32'(bus.err_drop), 32'd1);
    step(64'h0807060504030201, 8'hFF, 1'b0);
    step(64'h0, 8'h00, 1'b1);
    bus.out_ready = 1'b0;
    chk("pre_rst_idx", 32'(bus.out_chunk_idx), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    chk("midrst_mask", 32'(bus.out_lane_mask), 32'd0);
    chk("midrst_idx", 32'(bus.out_chunk_idx), 32'd0);
    chk("midrst_last", 32'(bus.out_last), 32'd0);
    chk("midrst_err", 32'(bus.err_drop), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    sb.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) step(64'h0, 8'h00, 1'b1);
    chk("no_stale_out_vld", 32'(bus.out_vld), 32'd0);
    for (int k = 0; k < 400; k++) begin
      logic [7:0] v;
      v = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'h00;
      step({$urandom, $urandom}, v, $urandom_range(0, 9) < 7);
    end
    drain(n);
    chk("final_out_vld", 32'(bus.out_vld), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
